// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-type codes, FSM states
// and small decode helpers used by both the FSM and the alignment logic.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        STORE_HI
    } lsu_state_t;

    function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: access_bytes = 3'd1;
            F3_H, F3_HU: access_bytes = 3'd2;
            default:     access_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic load_f3_ok(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: load_f3_ok = 1'b1;
            default:                        load_f3_ok = 1'b0;
        endcase
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: store_f3_ok = 1'b1;
            default:          store_f3_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory port between the load/store unit (master) and the memory (slave).
interface lsu_mem_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) ();

    logic [DM_ADDRESS-1:0] mem_addr;
    logic                  mem_re;
    logic [3:0]            mem_wr;
    logic [DATA_W-1:0]     mem_wd;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_addr,
        output mem_re,
        output mem_wr,
        output mem_wd,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_re,
        input  mem_wr,
        input  mem_wd,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: load byte extraction with sign/zero extension,
// and store byte-enable / data shifting across a two-word window.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [63:0] ld_pair_i,   // {upper word, lower word}
    input  logic [31:0] wd_i,
    output logic [31:0] ld_data_o,
    output logic [7:0]  be_o,
    output logic [63:0] sd_o
);

    logic [4:0]  shamt;
    logic [31:0] ld_word;
    logic [7:0]  be_base;

    assign shamt   = {off_i, 3'b000};
    assign ld_word = 32'(ld_pair_i >> shamt);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ld_data_o = '0;
        case (funct3_i)
            F3_B:    ld_data_o = {{24{ld_word[7]}}, ld_word[7:0]};
            F3_H:    ld_data_o = {{16{ld_word[15]}}, ld_word[15:0]};
            F3_W:    ld_data_o = ld_word;
            F3_BU:   ld_data_o = {24'b0, ld_word[7:0]};
            F3_HU:   ld_data_o = {16'b0, ld_word[15:0]};
            default: ld_data_o = '0;
        endcase
    end

    always_comb begin
        be_base = '0;
        case (funct3_i)
            F3_B:    be_base = 8'h01;
            F3_H:    be_base = 8'h03;
            F3_W:    be_base = 8'h0F;
            default: be_base = 8'h00;
        endcase
    end

    assign be_o = be_base << off_i;
    assign sd_o = {32'b0, wd_i} << shamt;

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns byte-addressed loads/stores into word-aligned
// memory requests, splitting word-crossing accesses into two memory cycles.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd,
    output logic                  done,
    output logic                  stall,
    output logic                  fault,
    lsu_mem_if.master             mem
);

    lsu_state_t state_q, state_d;
    logic [31:0] lo_buf_q, lo_buf_d;

    logic [1:0]            off;
    logic                  spans;
    logic                  illegal;
    logic [DM_ADDRESS-1:0] addr_w0;
    logic [DM_ADDRESS-1:0] addr_w1;
    logic [63:0]           ld_pair;
    logic [31:0]           ld_data;
    logic [7:0]            be;
    logic [63:0]           sd;

    assign off     = a[1:0];
    assign spans   = ({1'b0, off} + access_bytes(Funct3)) > 3'd4;
    assign addr_w0 = {a[DM_ADDRESS-1:2], 2'b00};
    assign addr_w1 = addr_w0 + DM_ADDRESS'(4);   // wraps to 0 at the top of memory

    assign illegal = (MemRead && MemWrite)
                   || (MemRead  && !load_f3_ok(Funct3))
                   || (MemWrite && !store_f3_ok(Funct3));

    // The high word only matters in LOAD_HI; a single-word load never reaches it.
    assign ld_pair = (state_q == LOAD_HI) ? {mem.mem_rdata, lo_buf_q}
                                          : {32'b0, mem.mem_rdata};

    lsu_align u_align (
        .funct3_i  (Funct3),
        .off_i     (off),
        .ld_pair_i (ld_pair),
        .wd_i      (wd),
        .ld_data_o (ld_data),
        .be_o      (be),
        .sd_o      (sd)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lo_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            lo_buf_q <= lo_buf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_buf_d = lo_buf_q;
        case (state_q)
            IDLE: begin
                if (!illegal) begin
                    if (MemRead)
                        state_d = LOAD_LO;
                    else if (MemWrite && spans)
                        state_d = STORE_HI;
                end
            end
            LOAD_LO: begin
                if (spans) begin
                    lo_buf_d = mem.mem_rdata;
                    state_d  = LOAD_HI;
                end else begin
                    state_d  = IDLE;
                end
            end
            LOAD_HI:  state_d = IDLE;
            STORE_HI: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        rd           = '0;
        done         = 1'b0;
        stall        = 1'b0;
        fault        = 1'b0;
        mem.mem_addr = '0;
        mem.mem_re   = 1'b0;
        mem.mem_wr   = '0;
        mem.mem_wd   = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (illegal) begin
                        fault = 1'b1;
                        done  = 1'b1;
                    end else if (MemRead) begin
                        mem.mem_re   = 1'b1;
                        mem.mem_addr = addr_w0;
                        stall        = 1'b1;
                    end else if (MemWrite) begin
                        mem.mem_addr = addr_w0;
                        mem.mem_wr   = be[3:0];
                        mem.mem_wd   = sd[31:0];
                        stall        = spans;
                        done         = !spans;
                    end
                end
                LOAD_LO: begin
                    if (spans) begin
                        mem.mem_re   = 1'b1;
                        mem.mem_addr = addr_w1;
                        stall        = 1'b1;
                    end else begin
                        rd   = ld_data;
                        done = 1'b1;
                    end
                end
                LOAD_HI: begin
                    rd   = ld_data;
                    done = 1'b1;
                end
                STORE_HI: begin
                    mem.mem_addr = addr_w1;
                    mem.mem_wr   = be[7:4];
                    mem.mem_wd   = sd[63:32];
                    done         = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte-lane memory model behind the port,
// a scoreboard of expected completions, and per-cycle checks of the memory requests.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        done, stall, fault;

    lsu_mem_if #(.DM_ADDRESS(9), .DATA_W(32)) mem_if ();

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Funct3   (Funct3),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .done     (done),
        .stall    (stall),
        .fault    (fault),
        .mem      (mem_if)
    );

    always #5 clk = ~clk;

    // Data memory: registered read one cycle after mem_re, byte-lane writes.
    logic [31:0] mem [128];
    logic [31:0] rdata_q;
    assign mem_if.mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (mem_if.mem_re)
            rdata_q <= mem[mem_if.mem_addr[8:2]];
        for (int b = 0; b < 4; b++)
            if (mem_if.mem_wr[b])
                mem[mem_if.mem_addr[8:2]][8*b +: 8] <= mem_if.mem_wd[8*b +: 8];
    end

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] tr_addr  [8];
    logic [31:0] tr_re    [8];
    logic [31:0] tr_wr    [8];
    logic [31:0] tr_wd    [8];
    logic [31:0] tr_stall [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the request dropped.
    task automatic issue(input string tag, input logic r, input logic w,
                         input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rd,
                         input logic exp_fault, input int exp_cycles);
        exp_t e;
        exp_t got_e;
        int   n;
        bit   got;
        e.rd     = exp_rd;
        e.fault  = exp_fault;
        e.cycles = exp_cycles;
        sb_q.push_back(e);
        MemRead  = r;
        MemWrite = w;
        Funct3   = f3;
        a        = addr;
        wd       = data;
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            #1;
            tr_addr[n]  = 32'(mem_if.mem_addr);
            tr_re[n]    = 32'(mem_if.mem_re);
            tr_wr[n]    = 32'(mem_if.mem_wr);
            tr_wd[n]    = mem_if.mem_wd;
            tr_stall[n] = 32'(stall);
            n++;
            if (done) begin
                got   = 1'b1;
                got_e = sb_q.pop_front();
                check({tag, "_rd"},     rd,          got_e.rd);
                check({tag, "_fault"},  32'(fault),  32'(got_e.fault));
                check({tag, "_cycles"}, 32'(n),      32'(got_e.cycles));
                check({tag, "_stall"},  32'(stall),  32'd0);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        Funct3   = F3_W;
        a        = 9'h010;
        wd       = 32'h0;
        rdata_q  = 32'h0;

        // Outputs held at zero in reset even with a request present.
        repeat (2) @(negedge clk);
        #1;
        check("rst_re",    32'(mem_if.mem_re), 32'd0);
        check("rst_stall", 32'(stall),         32'd0);
        check("rst_addr",  32'(mem_if.mem_addr), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        MemRead = 1'b0;
        #1;
        check("idle_addr", 32'(mem_if.mem_addr), 32'd0);
        check("idle_rd",   rd,                   32'd0);
        check("idle_done", 32'(done),            32'd0);
        @(negedge clk);

        // Aligned word store then load.
        issue("sw_010", 1'b0, 1'b1, F3_W, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        check("sw_010_addr", tr_addr[0], 32'h010);
        check("sw_010_wr",   tr_wr[0],   32'hF);
        check("sw_010_wd",   tr_wd[0],   32'hDEADBEEF);
        issue("lw_010", 1'b1, 1'b0, F3_W, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        check("lw_010_re0",    tr_re[0],    32'd1);
        check("lw_010_addr0",  tr_addr[0],  32'h010);
        check("lw_010_stall0", tr_stall[0], 32'd1);

        // Sign / zero extension of bytes and halves.
        issue("sw_sx", 1'b0, 1'b1, F3_W, 9'h010, 32'h80112233, 32'h0, 1'b0, 1);
        issue("lb_013",  1'b1, 1'b0, F3_B,  9'h013, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        issue("lbu_013", 1'b1, 1'b0, F3_BU, 9'h013, 32'h0, 32'h00000080, 1'b0, 2);
        issue("lh_012",  1'b1, 1'b0, F3_H,  9'h012, 32'h0, 32'hFFFF8011, 1'b0, 2);
        issue("lhu_012", 1'b1, 1'b0, F3_HU, 9'h012, 32'h0, 32'h00008011, 1'b0, 2);

        // Word load spanning 0x00C/0x010.
        issue("sw_00c", 1'b0, 1'b1, F3_W, 9'h00C, 32'h44332211, 32'h0, 1'b0, 1);
        issue("sw_010b", 1'b0, 1'b1, F3_W, 9'h010, 32'h88776655, 32'h0, 1'b0, 1);
        issue("lw_00d", 1'b1, 1'b0, F3_W, 9'h00D, 32'h0, 32'h55443322, 1'b0, 3);
        check("lw_00d_addr1",  tr_addr[1],  32'h010);
        check("lw_00d_stall1", tr_stall[1], 32'd1);
        check("lw_00d_re1",    tr_re[1],    32'd1);

        // Halfword store into the upper lanes.
        issue("sw_004", 1'b0, 1'b1, F3_W, 9'h004, 32'h0, 32'h0, 1'b0, 1);
        issue("sh_006", 1'b0, 1'b1, F3_H, 9'h006, 32'h0000ABCD, 32'h0, 1'b0, 1);
        check("sh_006_addr", tr_addr[0], 32'h004);
        check("sh_006_wr",   tr_wr[0],   32'hC);
        check("sh_006_wd",   tr_wd[0],   32'hABCD0000);
        issue("lw_004", 1'b1, 1'b0, F3_W, 9'h004, 32'h0, 32'hABCD0000, 1'b0, 2);

        // Spanning store wrapping from the top of memory to address 0.
        issue("sw_1fc", 1'b0, 1'b1, F3_W, 9'h1FC, 32'h0, 32'h0, 1'b0, 1);
        issue("sw_000", 1'b0, 1'b1, F3_W, 9'h000, 32'h0, 32'h0, 1'b0, 1);
        issue("sw_1fe", 1'b0, 1'b1, F3_W, 9'h1FE, 32'h11223344, 32'h0, 1'b0, 2);
        check("sw_1fe_addr0",  tr_addr[0],  32'h1FC);
        check("sw_1fe_wr0",    tr_wr[0],    32'hC);
        check("sw_1fe_wd0",    tr_wd[0],    32'h33440000);
        check("sw_1fe_stall0", tr_stall[0], 32'd1);
        check("sw_1fe_addr1",  tr_addr[1],  32'h000);
        check("sw_1fe_wr1",    tr_wr[1],    32'h3);
        check("sw_1fe_wd1",    tr_wd[1],    32'h00001122);
        issue("lw_1fc", 1'b1, 1'b0, F3_W, 9'h1FC, 32'h0, 32'h33440000, 1'b0, 2);
        issue("lw_000", 1'b1, 1'b0, F3_W, 9'h000, 32'h0, 32'h00001122, 1'b0, 2);
        issue("lh_1ff", 1'b1, 1'b0, F3_H, 9'h1FF, 32'h0, 32'h00002233, 1'b0, 3);
        check("lh_1ff_addr1", tr_addr[1], 32'h000);

        // Byte store at lane 3, then sign-extended byte load of it.
        issue("sb_003", 1'b0, 1'b1, F3_B, 9'h003, 32'h000000FF, 32'h0, 1'b0, 1);
        check("sb_003_wr", tr_wr[0], 32'h8);
        issue("lw_000b", 1'b1, 1'b0, F3_W, 9'h000, 32'h0, 32'hFF001122, 1'b0, 2);
        issue("lb_003",  1'b1, 1'b0, F3_B, 9'h003, 32'h0, 32'hFFFFFFFF, 1'b0, 2);

        // Illegal requests.
        issue("st_f3bu", 1'b0, 1'b1, F3_BU, 9'h010, 32'h12345678, 32'h0, 1'b1, 1);
        check("st_f3bu_wr", tr_wr[0], 32'h0);
        issue("ld_f3_011", 1'b1, 1'b0, 3'b011, 9'h010, 32'h0, 32'h0, 1'b1, 1);
        check("ld_f3_011_re", tr_re[0], 32'd0);
        issue("rw_both", 1'b1, 1'b1, F3_W, 9'h010, 32'h0, 32'h0, 1'b1, 1);
        check("rw_both_wr", tr_wr[0], 32'h0);
        check("rw_both_re", tr_re[0], 32'd0);

        // Reset while in LOAD_HI: aborted, no done afterwards.
        MemRead = 1'b1;
        Funct3  = F3_W;
        a       = 9'h00D;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_hi_done",  32'(done),  32'd0);
        check("rst_hi_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        MemRead = 1'b0;
        #1;
        check("post_rst_done",  32'(done),  32'd0);
        check("post_rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        issue("lw_after_rst", 1'b1, 1'b0, F3_W, 9'h010, 32'h0, 32'h88776655, 1'b0, 2);

        // Reset during STORE_HI keeps the first word written, drops the second.
        MemWrite = 1'b1;
        Funct3   = F3_W;
        a        = 9'h1FE;
        wd       = 32'hAABBCCDD;
        #1;
        check("rst_st_stall0", 32'(stall), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_st_wr", 32'(mem_if.mem_wr), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        issue("lw_1fc_rst", 1'b1, 1'b0, F3_W, 9'h1FC, 32'h0, 32'hCCDD0000, 1'b0, 2);
        issue("lw_000_rst", 1'b1, 1'b0, F3_W, 9'h000, 32'h0, 32'hFF001122, 1'b0, 2);

        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
